apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 147 ++++++++++++++
 tb/tb_apb_master.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB master: accepts one command at a time on a valid/ready port, runs a
// single APB SETUP/ACCESS transfer and returns a one-cycle completion pulse.
// An ACCESS phase that waits longer than TMO_CYC cycles is aborted with
// rsp_err set.
module apb_master #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // Last wait-count value allowed before the transfer is aborted.
    localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_wait_cnt;
    logic [7:0]        w_wait_cnt_nxt;
    logic              w_accept;
    logic              w_done_ok;
    logic              w_done_tmo;

    logic              r_cmd_ready;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rsp_rdata;

    // Next-state, wait-counter and completion decode for the transfer FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_accept       = 1'b0;
        w_done_ok      = 1'b0;
        w_done_tmo     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SETUP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                w_state_nxt    = ST_ACCESS;
                w_wait_cnt_nxt = 8'd0;
            end
            ST_ACCESS: begin
                // pready wins over the timeout when both occur together.
                if (pready) begin
                    w_done_ok   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_wait_cnt == TMO_LAST) begin
                    w_done_tmo  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Registered APB and response outputs, all decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd_ready <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_cmd_ready <= (w_state_nxt == ST_IDLE);
            r_psel      <= (w_state_nxt != ST_IDLE);
            r_penable   <= (w_state_nxt == ST_ACCESS);
            r_rsp_valid <= w_done_ok | w_done_tmo;
            r_rsp_err   <= w_done_tmo;
            // Command fields are captured once and held through the transfer.
            if (w_accept) begin
                r_paddr  <= cmd_addr;
                r_pwrite <= cmd_write;
                r_pwdata <= cmd_wdata;
            end
            // Only a successful read updates the returned data.
            if (w_done_ok && !r_pwrite) begin
                r_rsp_rdata <= prdata;
            end
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: stimulus pushes expected responses into a
// queue computed by a transaction-level model; a monitor pops and compares.
module tb_apb_master;

    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;

    apb_master #(.ADDR_W(AW), .DATA_W(DW), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          err;
        logic [DW-1:0] rdata;
        int            acc;
    } exp_t;

    typedef struct {
        int            delay;
        logic [DW-1:0] prdata;
    } slv_t;

    exp_t exp_q[$];
    slv_t slv_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic [DW-1:0] sb_rdata = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Transaction-level reference: a transfer waits 'delay' low-pready cycles;
    // if that reaches the timeout limit it aborts after exactly TMO cycles.
    function automatic exp_t model(input logic wr, input logic [AW-1:0] a,
                                   input logic [DW-1:0] d, input int delay,
                                   input logic [DW-1:0] prd, input logic [DW-1:0] prev);
        exp_t e;
        e.wr    = wr;
        e.addr  = a;
        e.wdata = d;
        e.err   = (delay >= TMO);
        e.acc   = e.err ? TMO : delay + 1;
        e.rdata = (!wr && !e.err) ? prd : prev;
        return e;
    endfunction

    // Issue one command; returns the cycle number in which it was accepted.
    task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int delay, input logic [DW-1:0] prd, output int acc_cyc);
        logic rdy;
        bit   done;
        exp_t e;
        slv_t s;
        done      = 1'b0;
        acc_cyc   = -1;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            rdy     = cmd_ready;
            acc_cyc = cyc;
            @(posedge clk);
            if (rdy) begin
                e        = model(wr, a, d, delay, prd, sb_rdata);
                sb_rdata = e.rdata;
                exp_q.push_back(e);
                s.delay  = delay;
                s.prdata = prd;
                slv_q.push_back(s);
                done     = 1'b1;
            end
        end
        chk("accept", 32'(done), 32'd1);
        #1;
        cmd_valid = 1'b0;
    endtask

    // APB slave: holds pready low for 'delay' ACCESS cycles, random elsewhere.
    slv_t cur;
    int   s_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            pready = 1'b0;
            s_cnt  = 0;
        end else if (psel && !penable) begin
            if (slv_q.size() > 0) begin
                cur = slv_q.pop_front();
            end else begin
                cur.delay  = 0;
                cur.prdata = '0;
            end
            s_cnt  = 0;
            pready = 1'($urandom_range(0, 1));
            prdata = $urandom;
        end else if (psel && penable) begin
            if (s_cnt == cur.delay) begin
                pready = 1'b1;
                prdata = cur.prdata;
            end else begin
                pready = 1'b0;
                prdata = $urandom;
            end
            s_cnt++;
        end else begin
            pready = 1'($urandom_range(0, 1));
            prdata = $urandom;
        end
    end

    // Monitor: protocol rules every cycle, scoreboard compare on rsp_valid.
    int            m_acc = 0;
    int            m_setup = 0;
    logic [DW-1:0] m_rdata = '0;
    exp_t          m_e;
    always @(negedge clk) begin
        if (rst) begin
            m_acc   = 0;
            m_setup = 0;
            m_rdata = '0;
        end else begin
            chk("penable_without_psel", 32'(penable & ~psel), 32'd0);
            chk("psel_in_idle", 32'(psel & cmd_ready), 32'd0);
            chk("err_without_valid", 32'(rsp_err & ~rsp_valid), 32'd0);
            if (psel) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_psel", 32'd1, 32'd0);
                end else begin
                    m_e = exp_q[0];
                    chk("paddr", 32'(paddr), 32'(m_e.addr));
                    chk("pwrite", 32'(pwrite), 32'(m_e.wr));
                    chk("pwdata", pwdata, m_e.wdata);
                end
                if (penable) m_acc++;
                else m_setup++;
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    m_e     = exp_q.pop_front();
                    m_rdata = m_e.rdata;
                    chk("rsp_err", 32'(rsp_err), 32'(m_e.err));
                    chk("rsp_rdata", rsp_rdata, m_e.rdata);
                    chk("access_cycles", 32'(m_acc), 32'(m_e.acc));
                    chk("setup_cycles", 32'(m_setup), 32'd1);
                end
                m_acc   = 0;
                m_setup = 0;
            end else begin
                chk("rdata_hold", rsp_rdata, m_rdata);
            end
        end
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    int t;
    int a[4];
    bit seen;

    // Main stimulus sequence.
    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        pready    = 1'b0;
        prdata    = '0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_paddr", 32'(paddr), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single-cycle-ACCESS write.
        send(1'b1, 12'h0A4, 32'hDEADBEEF, 0, 32'h0, t);
        // Read with three wait cycles.
        send(1'b0, 12'h010, 32'h0, 3, 32'h12345678, t);
        // Timeout: pready never rises.
        send(1'b0, 12'h200, 32'h0, 100, 32'h55AA55AA, t);
        // pready rises in the last allowed ACCESS cycle.
        send(1'b0, 12'h204, 32'h0, TMO - 1, 32'hA5A50001, t);
        // Back-to-back: four commands with cmd_valid effectively held high.
        for (int i = 0; i < 4; i++) begin
            send(1'(i), 12'(12'h300 + 12'(4 * i)), $urandom, 0, $urandom, a[i]);
        end
        for (int i = 1; i < 4; i++) begin
            chk("b2b_spacing", 32'(a[i] - a[i-1]), 32'd3);
        end

        // Reset in the middle of an ACCESS phase of a write.
        send(1'b1, 12'h3C0, 32'hCAFEF00D, 10, 32'h0, t);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = psel && penable;
        end
        chk("reach_access", 32'(seen), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_psel", 32'(psel), 32'd0);
        chk("arst_penable", 32'(penable), 32'd0);
        chk("arst_pwrite", 32'(pwrite), 32'd0);
        chk("arst_paddr", 32'(paddr), 32'd0);
        chk("arst_pwdata", pwdata, 32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_rsp_err", 32'(rsp_err), 32'd0);
        chk("arst_rsp_rdata", rsp_rdata, 32'd0);
        chk("arst_cmd_ready", 32'(cmd_ready), 32'd0);
        exp_q.delete();
        slv_q.delete();
        sb_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        send(1'b0, 12'h044, 32'h0, 2, 32'h0BADC0DE, t);

        // Randomized traffic, with occasional timeouts and idle gaps.
        for (int i = 0; i < 40; i++) begin
            int dly;
            dly = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TMO, TMO + 4))
                                               : int'($urandom_range(0, TMO - 1));
            send(1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)), $urandom,
                 dly, $urandom, t);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end

        for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(posedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
